// File: rtl/fft_controller.sv
// Sequencer for a 64-point in-place radix-2 DIT FFT: bit-reversed load, 6x32 butterflies, natural-order unload.
// Define FFT_AUTO_RESTART_EN to re-enter LOAD straight after the last bin instead of waiting in IDLE.
module fft_controller #(
  parameter int N_LOG2 = 6,
  parameter int WIDTH  = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [WIDTH-1:0]  sample_data,
  input  logic              sample_valid,
  output logic              sample_ready,
  input  logic [WIDTH-1:0]  bfly_a,
  input  logic [WIDTH-1:0]  bfly_b,
  output logic              ram_write,
  output logic [N_LOG2-1:0] ram_address_a,
  output logic [N_LOG2-1:0] ram_address_b,
  output logic [WIDTH-1:0]  ram_d_a,
  output logic [WIDTH-1:0]  ram_d_b,
  input  logic [WIDTH-1:0]  ram_q_a,
  output logic [N_LOG2-2:0] twiddle_address,
  output logic [WIDTH-1:0]  out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam int TW = N_LOG2 - 1;
  localparam logic [N_LOG2-1:0] ONE   = 1;
  localparam logic [N_LOG2-1:0] C_END = '1;
  localparam logic [TW-1:0]     I_END = '1;
  localparam logic [2:0]        S_END = 3'(N_LOG2 - 1);
  localparam logic [2:0]        TWS   = 3'(TW);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    COMPUTE,
    UNLOAD
  } state_t;

  state_t            state_q, state_d;
  logic [N_LOG2-1:0] cnt_q, cnt_d;
  logic [2:0]        s_q, s_d;
  logic [TW-1:0]     i_q, i_d;
  logic              ph_q, ph_d;
  logic              done_q, done_d;

  logic [N_LOG2-1:0] span, mask, hi, bf_a, bf_b;
  logic [TW-1:0]     pos, tw;

  function automatic logic [N_LOG2-1:0] bitrev(
    input logic [N_LOG2-1:0] x
  );
    logic [N_LOG2-1:0] r;
    for (int k = 0; k < N_LOG2; k++) begin
      r[k] = x[N_LOG2-1-k];
    end
    return r;
  endfunction

  // butterfly pair and twiddle index for stage s, butterfly i
  always_comb begin
    span = ONE << s_q;
    mask = span - ONE;
    pos  = i_q & mask[TW-1:0];
    hi   = ({1'b0, i_q} >> s_q) << (s_q + 3'd1);
    bf_a = hi | {1'b0, pos};
    bf_b = bf_a + span;
    tw   = pos << (TWS - s_q);
  end

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    s_d             = s_q;
    i_d             = i_q;
    ph_d            = ph_q;
    done_d          = 1'b0;
    sample_ready    = 1'b0;
    ram_write       = 1'b0;
    ram_address_a   = '0;
    ram_address_b   = '0;
    ram_d_a         = '0;
    ram_d_b         = '0;
    twiddle_address = '0;
    out_data        = '0;
    out_valid       = 1'b0;
    out_last        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          cnt_d   = '0;
        end
      end
      LOAD: begin
        sample_ready = 1'b1;
        if (sample_valid) begin
          ram_write     = 1'b1;
          ram_address_a = bitrev(cnt_q);
          ram_address_b = bitrev(cnt_q);
          ram_d_a       = sample_data;
          ram_d_b       = sample_data;
          cnt_d         = cnt_q + ONE;
          if (cnt_q == C_END) begin
            state_d = COMPUTE;
            s_d     = '0;
            i_d     = '0;
            ph_d    = 1'b0;
          end
        end
      end
      COMPUTE: begin
        ram_address_a   = bf_a;
        ram_address_b   = bf_b;
        twiddle_address = tw;
        ph_d            = ~ph_q;
        if (ph_q) begin
          ram_write = 1'b1;
          ram_d_a   = bfly_a;
          ram_d_b   = bfly_b;
          i_d       = i_q + 1'b1;
          if (i_q == I_END) begin
            s_d = s_q + 3'd1;
            if (s_q == S_END) begin
              state_d = UNLOAD;
              cnt_d   = '0;
              s_d     = '0;
            end
          end
        end
      end
      UNLOAD: begin
        ram_address_a = cnt_q;
        ram_address_b = cnt_q;
        out_data      = ram_q_a;
        out_valid     = 1'b1;
        out_last      = (cnt_q == C_END);
        if (out_ready) begin
          cnt_d = cnt_q + ONE;
          if (cnt_q == C_END) begin
            done_d = 1'b1;
`ifdef FFT_AUTO_RESTART_EN
            state_d = LOAD;
`else
            state_d = IDLE;
`endif
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      s_q     <= '0;
      i_q     <= '0;
      ph_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      i_q     <= i_d;
      ph_q    <= ph_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;

endmodule
